unpooling_unit: RTL and testbench
=================================

UNPOOLING_UNIT -- requirements
Module: unpooling_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the sample width in bits.
REQ-002 The block SHALL have parameter KERNEL_SIZE, default 2, giving the window edge; WINDOW = KERNEL_SIZE*KERNEL_SIZE output beats are produced per input sample.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 s_axis_tvalid  input  1  upstream sample valid.
REQ-006 s_axis_tready  output  1  block can accept a sample.
REQ-007 s_axis_tdata  input  DATA_WIDTH  pooled sample to expand.
REQ-008 s_axis_tlast  input  1  sample is the last of its frame.
REQ-009 unpool_type  input  1  0 = replicate (nearest-neighbour), 1 = zero-insert.
REQ-010 m_axis_tvalid  output  1  output beat valid.
REQ-011 m_axis_tready  input  1  downstream accepts beat.
REQ-012 m_axis_tdata  output  DATA_WIDTH  expanded window element.
REQ-013 m_axis_tlast  output  1  final beat of a frame.

Function
REQ-014 FSM states SHALL be IDLE (no sample held) and EMIT (sample held, beats outstanding).
REQ-015 A sample SHALL be accepted when s_axis_tvalid && s_axis_tready; data, tlast and unpool_type SHALL be latched at that edge.
REQ-016 unpool_type changes after acceptance SHALL NOT affect the group already latched.
REQ-017 s_axis_tready SHALL be 1 in IDLE, and in EMIT only when beat counter == WINDOW-1 && m_axis_tready (combinational path from m_axis_tready).
REQ-018 An accept in IDLE SHALL move to EMIT with beat counter 0; m_axis_tvalid rises the next cycle (latency 1).
REQ-019 In EMIT, m_axis_tvalid SHALL be 1; each m_axis handshake SHALL increment the beat counter (width clog2(WINDOW), minimum 1).
REQ-020 The handshake at beat WINDOW-1 SHALL move to IDLE, unless a sample is accepted in the same cycle, in which case the FSM stays in EMIT, restarts at beat 0 with the new sample, and leaves no bubble.
REQ-021 Replicate mode: m_axis_tdata SHALL equal the latched sample on every beat.
REQ-022 Zero-insert mode: m_axis_tdata SHALL equal the latched sample on beat 0 and 0 on beats 1..WINDOW-1.
REQ-023 m_axis_tlast SHALL be 1 only on beat WINDOW-1 of a group whose latched tlast was 1.
REQ-024 m_axis_tdata and m_axis_tlast SHALL hold stable while m_axis_tvalid && !m_axis_tready.
REQ-025 Sustained throughput SHALL be one output beat per cycle when the input never starves and m_axis_tready stays 1.
REQ-026 No arithmetic widening SHALL occur; output width equals input width.

Reset
REQ-027 On reset, the FSM SHALL go to IDLE, the beat counter and latched data/last/mode SHALL clear to 0, and m_axis_tvalid, m_axis_tdata and m_axis_tlast SHALL be 0.
REQ-028 While reset is asserted, s_axis_tready SHALL be 0; after deassertion it SHALL be 1.
REQ-029 Reset during EMIT SHALL discard the group with no residual beats.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, EMIT) and unpool mode constants (MODE_REPLICATE=0, MODE_ZERO_INSERT=1), shared with pooling_unit's pool_type encoding.
REQ-031 WINDOW and the counter width SHALL be derived localparams.
REQ-032 The block SHALL be a single module with no sub-module; the latched sample register is the only storage.

Verification
REQ-033 Replicate: KERNEL_SIZE=2, input 0x5A, tlast=1, m_tready=1 -> beats 0x5A x4; tlast only on beat 4; first valid 1 cycle after accept.
REQ-034 Zero-insert: input 0x7F, unpool_type=1 -> beats 0x7F, 0x00, 0x00, 0x00; tlast=0 throughout.
REQ-035 Back-to-back: inputs 0x11 and 0x22 held valid, m_tready=1 -> 8 consecutive beats (0x11 x4, 0x22 x4) with no bubble; s_tready pulses on beat 4.
REQ-036 Backpressure: m_tready=0 for 3 cycles at beat 2 -> data and tlast held stable, s_tready=0, resumes at beat 2.
REQ-037 Mode toggle: unpool_type flipped 0->1 during a replicate group -> that group stays replicated; the next accepted group is zero-inserted.
REQ-038 Reset mid-group: assert reset after beat 1 -> m_tvalid=0 immediately; after release, s_tready=1 and no leftover beats are produced.

Source files
------------

// File: rtl/unpooling_unit_pkg.sv
// Shared definitions for the unpooling datapath: FSM state encoding and the
// unpool/pool mode encoding also used by pooling_unit's pool_type.
package unpooling_unit_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } unpool_state_e;

    localparam logic MODE_REPLICATE   = 1'b0;
    localparam logic MODE_ZERO_INSERT = 1'b1;

endpackage

// File: rtl/unpooling_unit.sv
// Expands each pooled input sample into a KERNEL_SIZE x KERNEL_SIZE window of
// output beats, either replicating the sample or zero-filling all but beat 0.
module unpooling_unit
    import unpooling_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  unpool_type,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast
);

    localparam int WINDOW = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WINDOW - 1);

    unpool_state_e         state_r;
    unpool_state_e         state_s;
    logic [CNT_W-1:0]      beat_r;
    logic [CNT_W-1:0]      beat_s;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  last_r;
    logic                  mode_r;
    logic                  accept_s;
    logic                  out_hs_s;
    logic                  final_beat_s;

    assign final_beat_s = (state_r == EMIT) && (beat_r == LAST_BEAT);
    assign out_hs_s     = (state_r == EMIT) && m_axis_tready;
    assign accept_s     = s_axis_tvalid && s_axis_tready;

    // Ready while idle, or on the final beat being taken so groups chain with no bubble
    assign s_axis_tready = !reset && ((state_r == IDLE) || (final_beat_s && m_axis_tready));

    // Next-state and beat counter decode
    always_comb begin
        state_s = state_r;
        beat_s  = beat_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = EMIT;
                    beat_s  = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            EMIT: begin
                if (out_hs_s && (beat_r == LAST_BEAT)) begin
                    beat_s  = {CNT_W{1'b0}};
                    state_s = accept_s ? EMIT : IDLE;
                end else if (out_hs_s) begin
                    beat_s = beat_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    beat_s = beat_r;
                end
            end
            default: begin
                state_s = IDLE;
                beat_s  = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            beat_r  <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            beat_r  <= beat_s;
        end
    end

    // Sample, frame-end flag and mode are captured together so later mode changes
    // cannot alter a group in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= {DATA_WIDTH{1'b0}};
            last_r <= 1'b0;
            mode_r <= MODE_REPLICATE;
        end else if (accept_s) begin
            data_r <= s_axis_tdata;
            last_r <= s_axis_tlast;
            mode_r <= unpool_type;
        end else begin
            data_r <= data_r;
            last_r <= last_r;
            mode_r <= mode_r;
        end
    end

    // Output decode depends only on registers, so data holds under backpressure
    always_comb begin
        m_axis_tvalid = (state_r == EMIT);
        m_axis_tdata  = {DATA_WIDTH{1'b0}};
        m_axis_tlast  = 1'b0;
        if (state_r == EMIT) begin
            if ((mode_r == MODE_ZERO_INSERT) && (beat_r != {CNT_W{1'b0}})) begin
                m_axis_tdata = {DATA_WIDTH{1'b0}};
            end else begin
                m_axis_tdata = data_r;
            end
            m_axis_tlast = last_r && (beat_r == LAST_BEAT);
        end else begin
            m_axis_tdata = {DATA_WIDTH{1'b0}};
            m_axis_tlast = 1'b0;
        end
    end

endmodule

// File: tb/tb_unpooling_unit.sv
// Self-checking bench for unpooling_unit: directed scenarios plus random traffic
// compared against a queue-based model of the expected output beat stream.
module tb_unpooling_unit;

    localparam int DW = 8;
    localparam int KS = 2;
    localparam int W  = KS * KS;

    logic          clk;
    logic          reset;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          unpool_type;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    int            n_checks;
    int            n_fail;
    logic          stall_prev;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    unpooling_unit #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .unpool_type   (unpool_type),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, update the model
    task automatic cycle(input logic sv, input logic [DW-1:0] d, input logic l,
                         input logic t, input logic mr);
        logic exp_ready;
        logic acc;
        logic hs;
        @(negedge clk);
        s_axis_tvalid = sv;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        unpool_type   = t;
        m_axis_tready = mr;
        #1;
        exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && mr);
        check_value("s_tready", 32'(s_axis_tready), 32'(exp_ready));
        check_value("m_tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_value("m_tdata", 32'(m_axis_tdata), 32'(exp_q[0].data));
            check_value("m_tlast", 32'(m_axis_tlast), 32'(exp_q[0].last));
        end
        if (stall_prev) begin
            check_value("hold_tdata", 32'(m_axis_tdata), 32'(prev_data));
            check_value("hold_tlast", 32'(m_axis_tlast), 32'(prev_last));
        end
        acc = sv && s_axis_tready;
        hs  = m_axis_tvalid && mr;
        if (hs && (exp_q.size() != 0)) void'(exp_q.pop_front());
        if (acc) begin
            for (int i = 0; i < W; i++) begin
                beat_t b;
                b.data = (t && (i != 0)) ? '0 : d;
                b.last = l && (i == W - 1);
                exp_q.push_back(b);
            end
        end
        stall_prev = m_axis_tvalid && !mr;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check_value({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
        check_value({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
        check_value({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        stall_prev    = 1'b0;
        prev_data     = '0;
        prev_last     = 1'b0;
        reset         = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        unpool_type   = 1'b0;
        m_axis_tready = 1'b0;
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_value("post_rst_tready", 32'(s_axis_tready), 32'd1);

        // Replicate 0x5A with frame end
        cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Zero-insert 0x7F
        cycle(1'b1, 8'h7F, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Back-to-back 0x11 then 0x22, held valid until accepted
        cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Backpressure at beat 2 for 3 cycles
        cycle(1'b1, 8'hC3, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Mode flipped mid-group, next group picks up the new mode
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 8'hB6, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset after beat 1 discards the rest of the group
        cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4 * W; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_value("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
